// File: rtl/sid_reg_arb_if.sv
// sid_reg_arb_if: requester handshakes plus the shared register write port.
interface sid_reg_arb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              iReqA;
  logic [ADDR_W-1:0] iAddrA;
  logic [DATA_W-1:0] iDataA;
  logic              oAckA;
  logic              iReqB;
  logic [ADDR_W-1:0] iAddrB;
  logic [DATA_W-1:0] iDataB;
  logic              oAckB;
  logic              oWE;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] oData;
  logic              oLastB;
  logic              oBusy;
  modport master (
    output iReqA, iAddrA, iDataA, iReqB, iAddrB, iDataB,
    input  oAckA, oAckB, oWE, oAddr, oData, oLastB, oBusy
  );
  modport slave (
    input  iReqA, iAddrA, iDataA, iReqB, iAddrB, iDataB,
    output oAckA, oAckB, oWE, oAddr, oData, oLastB, oBusy
  );
endinterface

// File: rtl/sid_reg_arb.sv
// sid_reg_arb: two-requester register write arbiter, one-entry slot per requester,
// one write per IDLE->ISSUE->GAP pass so gate/ADSR writes are never merged.
module sid_reg_arb #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int MIN_GAP   = 1,
  parameter int PRIO_MODE = 0
) (
  input logic          clk,
  input logic          iRstN,
  sid_reg_arb_if.slave bus
);
  localparam int CW = MIN_GAP > 0 ? $clog2(MIN_GAP + 1) : 1;
  localparam int WW = ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] gap_q, gap_d;
  logic          full_a_q, full_a_d, full_b_q, full_b_d;
  logic          ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic [WW-1:0] slot_a_q, slot_a_d, slot_b_q, slot_b_d, word_q, word_d;
  logic          we_q, we_d, last_b_q, last_b_d;
  logic          issue, win_b, cap_a, cap_b;
  assign issue = state_q == IDLE && (full_a_q || full_b_q);
  assign win_b = full_b_q && (!full_a_q || (PRIO_MODE == 0 && !last_b_q));
  // a slot being drained this edge may refill on the same edge, unless its ack is still showing
  assign cap_a = bus.iReqA && !ack_a_q && (!full_a_q || (issue && !win_b));
  assign cap_b = bus.iReqB && !ack_b_q && (!full_b_q || (issue && win_b));
  always_ff @(posedge clk or negedge iRstN)
    if (!iRstN) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  always_comb begin
    state_d = issue ? ISSUE :
              state_q == ISSUE ? (MIN_GAP > 0 ? GAP : IDLE) :
              (state_q == GAP && gap_q == CW'(MIN_GAP - 1)) ? IDLE : state_q;
    gap_d   = state_q == GAP ? gap_q + CW'(1) : '0;
  end
  always_comb begin
    we_d     = issue;
    word_d   = issue ? (win_b ? slot_b_q : slot_a_q) : word_q;
    last_b_d = issue ? win_b : last_b_q;
    full_a_d = cap_a || (full_a_q && !(issue && !win_b));
    full_b_d = cap_b || (full_b_q && !(issue && win_b));
    slot_a_d = cap_a ? {bus.iAddrA, bus.iDataA} : slot_a_q;
    slot_b_d = cap_b ? {bus.iAddrB, bus.iDataB} : slot_b_q;
    ack_a_d  = cap_a;
    ack_b_d  = cap_b;
  end
  always_ff @(posedge clk or negedge iRstN)
    if (!iRstN) begin
      we_q     <= 1'b0;
      word_q   <= '0;
      last_b_q <= 1'b1;
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
      slot_a_q <= '0;
      slot_b_q <= '0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      word_q   <= word_d;
      last_b_q <= last_b_d;
      full_a_q <= full_a_d;
      full_b_q <= full_b_d;
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
    end
  assign bus.oWE    = we_q;
  assign bus.oAddr  = word_q[WW-1:DATA_W];
  assign bus.oData  = word_q[DATA_W-1:0];
  assign bus.oLastB = last_b_q;
  assign bus.oAckA  = ack_a_q;
  assign bus.oAckB  = ack_b_q;
  assign bus.oBusy  = full_a_q || full_b_q || state_q != IDLE;
endmodule

// File: tb/tb_sid_reg_arb.sv
// tb_sid_reg_arb: scoreboard bench; round-robin instance u_rr carries most traffic,
// fixed-priority instance u_fp covers A-always-wins starvation of B.
module tb_sid_reg_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sid_reg_arb_if #(.ADDR_W(5), .DATA_W(8)) br ();
  sid_reg_arb_if #(.ADDR_W(5), .DATA_W(8)) bf ();
  sid_reg_arb #(.ADDR_W(5), .DATA_W(8), .MIN_GAP(1), .PRIO_MODE(0)) u_rr (.clk(clk), .iRstN(rst_n), .bus(br));
  sid_reg_arb #(.ADDR_W(5), .DATA_W(8), .MIN_GAP(1), .PRIO_MODE(1)) u_fp (.clk(clk), .iRstN(rst_n), .bus(bf));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  logic [12:0] qa[$], qb[$];
  int          wr_cyc[$];
  bit          wr_src[$];
  int          last_we = -100, ack_a_cnt = 0, ack_b_cnt = 0;
  int          fp_a_wr = 0, fp_b_wr = 0, fp_ackb = 0;
  logic [12:0] fp_b_word = '0, snap_a = '0, snap_b = '0;
  logic        req_a_e = 1'b0, req_b_e = 1'b0;
  // words as presented at each capture edge; an ack one cycle later pushes them
  always @(posedge clk) begin
    snap_a  <= {br.iAddrA, br.iDataA};
    snap_b  <= {br.iAddrB, br.iDataB};
    req_a_e <= br.iReqA;
    req_b_e <= br.iReqB;
  end
  always @(negedge clk) begin
    if (br.oAckA) begin
      check("ack_a_req", req_a_e, 1);
      qa.push_back(snap_a);
      ack_a_cnt++;
    end
    if (br.oAckB) begin
      check("ack_b_req", req_b_e, 1);
      qb.push_back(snap_b);
      ack_b_cnt++;
    end
    if (br.oWE) begin
      check("we_gap", cyc - last_we >= 3, 1);
      last_we = cyc;
      wr_cyc.push_back(cyc);
      wr_src.push_back(br.oLastB);
      if (br.oLastB) begin
        if (qb.size() == 0) check("sb_b_pending", qb.size(), 1);
        else check("sb_b_word", {br.oAddr, br.oData}, qb.pop_front());
      end else begin
        if (qa.size() == 0) check("sb_a_pending", qa.size(), 1);
        else check("sb_a_word", {br.oAddr, br.oData}, qa.pop_front());
      end
    end
    if (bf.oWE && bf.oLastB) begin
      fp_b_wr++;
      fp_b_word = {bf.oAddr, bf.oData};
    end
    if (bf.oWE && !bf.oLastB) fp_a_wr++;
    if (bf.oAckB) fp_ackb++;
  end
  task automatic drive(input bit fp, input bit b, input logic r, input logic [4:0] a, input logic [7:0] d);
    if (fp && b) begin bf.iReqB = r; bf.iAddrB = a; bf.iDataB = d; end
    else if (fp) begin bf.iReqA = r; bf.iAddrA = a; bf.iDataA = d; end
    else if (b) begin br.iReqB = r; br.iAddrB = a; br.iDataB = d; end
    else begin br.iReqA = r; br.iAddrA = a; br.iDataA = d; end
  endtask
  function automatic logic acked(input bit fp, input bit b);
    return fp ? (b ? bf.oAckB : bf.oAckA) : (b ? br.oAckB : br.oAckA);
  endfunction
  task automatic send(input bit fp, input bit b, input logic [4:0] a, input logic [7:0] d, output int ac);
    ac = -1;
    drive(fp, b, 1'b1, a, d);
    for (int i = 0; i < 40 && ac < 0; i++) begin
      @(negedge clk);
      if (acked(fp, b)) ac = cyc;
    end
    drive(fp, b, 1'b0, a, d);
    check(b ? "ack_seen_b" : "ack_seen_a", ac >= 0, 1);
  endtask
  task automatic wait_wr(input int n, input string tag);
    for (int i = 0; i < 80 && wr_cyc.size() < n; i++) @(negedge clk);
    @(negedge clk);
    check(tag, wr_cyc.size(), n);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c0, ac, ac2, n0, a0;
    drive(0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_we", br.oWE, 0);
    check("rst_addr", br.oAddr, 0);
    check("rst_data", br.oData, 0);
    check("rst_acka", br.oAckA, 0);
    check("rst_ackb", br.oAckB, 0);
    check("rst_busy", br.oBusy, 0);
    check("rst_lastb", br.oLastB, 1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t1_idle_we", wr_cyc.size(), 0);
    // single A write: ack in cycle 1, strobe in cycle 2, next A write no earlier than cycle 5
    c0 = cyc;
    send(0, 0, 5'h05, 8'h3C, ac);
    check("t2_ack_cyc", ac, c0 + 1);
    send(0, 0, 5'h05, 8'h77, ac2);
    wait_wr(2, "t2_wr_count");
    check("t2_we_cyc", wr_cyc[0], c0 + 2);
    check("t2_we2_min", wr_cyc[1] >= c0 + 5, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_lastb", br.oLastB, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n0 = wr_cyc.size();
    c0 = cyc;
    fork
      send(0, 0, 5'h04, 8'h41, ac);
      send(0, 1, 5'h0B, 8'h20, ac2);
    join
    wait_wr(n0 + 2, "t3_wr_count");
    check("t3_a_cyc", wr_cyc[n0], c0 + 2);
    check("t3_b_cyc", wr_cyc[n0 + 1], c0 + 5);
    check("t3_lastb_1st", wr_src[n0], 0);
    check("t3_lastb_2nd", wr_src[n0 + 1], 1);
    repeat (3) @(negedge clk);
    n0 = wr_cyc.size();
    fork
      for (int i = 0; i < 4; i++) send(0, 0, 5'(5'h10 + i), 8'(8'h50 + i), ac);
      for (int j = 0; j < 4; j++) send(0, 1, 5'(5'h10 + j), 8'(8'h90 + j), ac2);
    join
    wait_wr(n0 + 8, "t4_wr_count");
    for (int i = 0; i < 8; i++) check("t4_alternate", wr_src[n0 + i], i % 2);
    fork
      for (int i = 0; i < 6; i++) send(1, 0, 5'(5'h03 + i), 8'(8'hC0 + i), ac);
      begin
        send(1, 1, 5'h1F, 8'hB7, ac2);
        drive(1, 1, 1'b1, 5'h1E, 8'hEE);
      end
    join
    check("t4fp_b_starved", fp_b_wr, 0);
    check("t4fp_b_one_ack", fp_ackb, 1);
    check("t4fp_busy", bf.oBusy, 1);
    check("t4fp_a_wrs", fp_a_wr >= 4, 1);
    drive(1, 1, 1'b0, 5'h1E, 8'hEE);
    for (int i = 0; i < 40 && fp_b_wr == 0; i++) @(negedge clk);
    check("t4fp_b_wr", fp_b_wr, 1);
    check("t4fp_b_word", fp_b_word, {5'h1F, 8'hB7});
    check("t4fp_a_total", fp_a_wr, 6);
    check("t4fp_b_acks", fp_ackb, 1);
    repeat (3) @(negedge clk);
    fork
      send(0, 0, 5'h01, 8'h11, ac);
      send(0, 1, 5'h02, 8'h22, ac2);
    join
    for (int i = 0; i < 10; i++) begin
      if (br.oWE) break;
      @(negedge clk);
    end
    check("t5_in_issue", br.oWE, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_we_async", br.oWE, 0);
    check("t5_busy_async", br.oBusy, 0);
    qa.delete();
    qb.delete();
    n0 = wr_cyc.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_wr", wr_cyc.size(), n0);
    check("t5_busy", br.oBusy, 0);
    // A held high with fresh data every cycle: one ack per drain, data as seen at each capture edge
    n0 = wr_cyc.size();
    a0 = ack_a_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1'b1, 5'h07, 8'(8'hA0 + i));
      @(negedge clk);
    end
    drive(0, 0, 1'b0, 5'h07, 8'h00);
    wait_wr(n0 + 4, "t6_wr_count");
    check("t6_acks", ack_a_cnt - a0, 4);
    check("t6_acks_vs_wr", ack_a_cnt - a0, wr_cyc.size() - n0);
    check("sb_a_left", qa.size(), 0);
    check("sb_b_left", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
